result_unloader: RTL and testbench

RESULT_UNLOADER -- requirements
Module: result_unloader

---
 rtl/result_unloader.sv | 146 ++++++++++++++
 tb/tb_result_unloader.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_unloader.sv
// Purpose : streams the active row_w x col_x window of a 3x3 MAC result array, row-major, one 10-bit element per beat.
// Latency : first valid_out 2 cycles after the unload_res rising edge; done pulses one cycle after the last accepted beat.
// Backpress: valid/ready; with ready_out low the current beat, last_out and counters hold. Macro RESULT_UNLOADER_CLAMP_EN clamps data_out to 255.
module result_unloader (
  input  logic        clk,
  input  logic        rst,
  input  logic        unload_res,
  input  logic [1:0]  row_w,
  input  logic [1:0]  col_x,
  input  logic [89:0] mac_res,
  input  logic        ready_out,
  output logic [9:0]  data_out,
  output logic        valid_out,
  output logic        last_out,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_SEND,
    ST_DONE
  } state_t;

  state_t      state_q, state_d;
  logic        unload_q, unload_d;
  // arm_q is set once unload_res has been seen low, so a level still high
  // coming out of reset cannot masquerade as a fresh rising edge.
  logic        arm_q, arm_d;
  logic [1:0]  row_q, row_d;
  logic [1:0]  col_q, col_d;
  logic [1:0]  r_q, r_d;
  logic [1:0]  c_q, c_d;
  logic [9:0]  elem_q [9];
  logic [9:0]  elem_d [9];

  logic        start;
  logic        is_last_col;
  logic        is_last_row;
  logic        xfer;
  logic [3:0]  idx;
  logic [9:0]  elem_sel;

  // Output datapath: select the current element and qualify it with SEND.
  always_comb begin
    idx         = 4'(r_q) * 4'd3 + 4'(c_q);
    elem_sel    = elem_q[idx];
    valid_out   = (state_q == ST_SEND);
    is_last_col = (c_q == col_q - 2'd1);
    is_last_row = (r_q == row_q - 2'd1);
    last_out    = valid_out && is_last_row && is_last_col;
    xfer        = valid_out && ready_out;
    busy        = (state_q == ST_CAPTURE) || (state_q == ST_SEND);
    done        = (state_q == ST_DONE);
    data_out    = '0;
    if (valid_out) begin
`ifdef RESULT_UNLOADER_CLAMP_EN
      data_out = (elem_sel > 10'd255) ? 10'd255 : elem_sel;
`else
      data_out = elem_sel;
`endif
    end
  end

  // Next-state: edge detect, FSM sequencing, capture and beat counters.
  always_comb begin
    state_d  = state_q;
    unload_d = unload_res;
    arm_d    = arm_q;
    row_d    = row_q;
    col_d    = col_q;
    r_d      = r_q;
    c_d      = c_q;
    elem_d   = elem_q;
    start    = unload_res && !unload_q && arm_q;

    if (!unload_res) begin
      arm_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          row_d   = row_w;
          col_d   = col_x;
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        for (int i = 0; i < 9; i++) begin
          elem_d[i] = mac_res[10*i +: 10];
        end
        r_d     = 2'd0;
        c_d     = 2'd0;
        state_d = ((row_q == 2'd0) || (col_q == 2'd0)) ? ST_DONE : ST_SEND;
      end
      ST_SEND: begin
        if (xfer) begin
          if (last_out) begin
            state_d = ST_DONE;
          end else if (is_last_col) begin
            c_d = 2'd0;
            r_d = r_q + 2'd1;
          end else begin
            c_d = c_q + 2'd1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset taking priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      unload_q <= 1'b0;
      arm_q    <= 1'b0;
      row_q    <= 2'd0;
      col_q    <= 2'd0;
      r_q      <= 2'd0;
      c_q      <= 2'd0;
      for (int i = 0; i < 9; i++) begin
        elem_q[i] <= 10'd0;
      end
    end else begin
      state_q  <= state_d;
      unload_q <= unload_d;
      arm_q    <= arm_d;
      row_q    <= row_d;
      col_q    <= col_d;
      r_q      <= r_d;
      c_q      <= c_d;
      for (int i = 0; i < 9; i++) begin
        elem_q[i] <= elem_d[i];
      end
    end
  end

endmodule

// File: tb/tb_result_unloader.sv
// Bench for result_unloader: queue-based reference model checked every cycle,
// directed transfers with literal expectations, then a randomized soak.
`timescale 1ns/1ps
module tb_result_unloader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        unload_res = 1'b0;
  logic [1:0]  row_w = 2'd0;
  logic [1:0]  col_x = 2'd0;
  logic [89:0] mac_res = '0;
  logic        ready_out = 1'b1;
  logic [9:0]  data_out;
  logic        valid_out;
  logic        last_out;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  result_unloader dut (
    .clk        (clk),
    .rst        (rst),
    .unload_res (unload_res),
    .row_w      (row_w),
    .col_x      (col_x),
    .mac_res    (mac_res),
    .ready_out  (ready_out),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .last_out   (last_out),
    .busy       (busy),
    .done       (done)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [9:0] exp_val(input logic [9:0] x);
`ifdef RESULT_UNLOADER_CLAMP_EN
    return (x > 10'd255) ? 10'd255 : x;
`else
    return x;
`endif
  endfunction

  // Reference model: phase 0 idle, 1 capture, 2 sending, 3 done pulse.
  // Pending beats live in a queue built from the active window.
  int          m_phase = 0;
  logic        m_prev  = 1'b0;
  logic        m_arm   = 1'b0;
  logic [1:0]  m_row   = 2'd0;
  logic [1:0]  m_col   = 2'd0;
  logic [9:0]  m_q [$];

  // Observations for directed checks.
  logic [9:0]  got_q [$];
  int          done_cyc  = -1;
  int          first_vld = -1;
  int          done_cnt  = 0;
  int          hold2     = 0;

  logic        e_vld, e_last, e_busy, e_done, rise;
  logic [9:0]  e_dat;

  // Compare DUT against model, log observations, then advance the model
  // using the inputs that the next rising edge will sample.
  always @(negedge clk) begin
    e_vld  = (m_phase == 2);
    e_dat  = e_vld ? exp_val(m_q[0]) : 10'd0;
    e_last = e_vld && (m_q.size() == 1);
    e_busy = (m_phase == 1) || (m_phase == 2);
    e_done = (m_phase == 3);
    check("valid_out", 32'(valid_out), 32'(e_vld));
    check("data_out",  32'(data_out),  32'(e_dat));
    check("last_out",  32'(last_out),  32'(e_last));
    check("busy",      32'(busy),      32'(e_busy));
    check("done",      32'(done),      32'(e_done));

    if (valid_out && ready_out) got_q.push_back(data_out);
    if (valid_out && first_vld < 0) first_vld = cyc;
    if (valid_out && data_out == 10'd2) hold2++;
    if (done) begin
      done_cyc = cyc;
      done_cnt++;
    end

    if (rst) begin
      m_phase = 0;
      m_prev  = 1'b0;
      m_arm   = 1'b0;
      m_q.delete();
    end else begin
      rise = unload_res && !m_prev && m_arm;
      case (m_phase)
        0: if (rise) begin
             m_row   = row_w;
             m_col   = col_x;
             m_phase = 1;
           end
        1: begin
             m_q.delete();
             for (int r = 0; r < int'(m_row); r++)
               for (int c = 0; c < int'(m_col); c++)
                 m_q.push_back(mac_res[10*(3*r+c) +: 10]);
             m_phase = (m_q.size() == 0) ? 3 : 2;
           end
        2: if (ready_out) begin
             void'(m_q.pop_front());
             if (m_q.size() == 0) m_phase = 3;
           end
        default: m_phase = 0;
      endcase
      m_prev = unload_res;
      if (!unload_res) m_arm = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    got_q.delete();
    done_cyc  = -1;
    first_vld = -1;
    hold2     = 0;
  endtask

  task automatic wait_done(input int budget);
    int start_cnt;
    start_cnt = done_cnt;
    for (int i = 0; i < budget && done_cnt == start_cnt; i++) tick();
    check("done_seen_within_budget", 32'(done_cnt != start_cnt), 32'd1);
    tick();
    tick();
  endtask

  function automatic logic [89:0] build(input int mode);
    logic [89:0] v;
    v = '0;
    for (int k = 0; k < 9; k++) begin
      case (mode)
        0:       v[10*k +: 10] = 10'(k + 1);
        1:       v[10*k +: 10] = 10'(10 * k);
        default: v[10*k +: 10] = (k == 0) ? 10'd700 : 10'(k + 1);
      endcase
    end
    return v;
  endfunction

  // Raises unload_res for one cycle; returns the cycle count just after the
  // edge was sampled. First beat is then expected at e+1, i.e. 2 cycles after
  // the edge was presented.
  task automatic start_xfer(input logic [1:0] r, input logic [1:0] c,
                            input logic [89:0] m, output int e);
    row_w      = r;
    col_x      = c;
    mac_res    = m;
    unload_res = 1'b1;
    tick();
    e          = cyc;
    unload_res = 1'b0;
  endtask

  initial begin
    int e;
    int n;
    int dc;

    repeat (3) tick();
    check("reset_valid", 32'(valid_out), 32'd0);
    check("reset_data",  32'(data_out),  32'd0);
    check("reset_busy",  32'(busy),      32'd0);
    check("reset_done",  32'(done),      32'd0);
    rst = 1'b0;
    tick();

    // Full 3x3, ready always high: beats 1..9 back to back.
    clear_log();
    start_xfer(2'd3, 2'd3, build(0), e);
    wait_done(30);
    check("t1_beats", 32'(got_q.size()), 32'd9);
    for (int i = 0; i < got_q.size() && i < 9; i++) check("t1_beat", 32'(got_q[i]), 32'(i + 1));
    check("t1_first_vld", 32'(first_vld), 32'(e + 1));
    check("t1_done_cyc",  32'(done_cyc),  32'(e + 10));

    // 2x3 window: 0,10,..,50 only.
    clear_log();
    start_xfer(2'd2, 2'd3, build(1), e);
    wait_done(30);
    check("t2_beats", 32'(got_q.size()), 32'd6);
    for (int i = 0; i < got_q.size() && i < 6; i++) check("t2_beat", 32'(got_q[i]), 32'(10 * i));

    // Backpressure on SEND cycles 2-4.
    clear_log();
    start_xfer(2'd3, 2'd3, build(0), e);
    tick();
    tick();
    ready_out = 1'b0;
    repeat (3) tick();
    ready_out = 1'b1;
    wait_done(30);
    check("t3_beats", 32'(got_q.size()), 32'd9);
    for (int i = 0; i < got_q.size() && i < 9; i++) check("t3_beat", 32'(got_q[i]), 32'(i + 1));
    // Three stalled cycles plus the accepting one.
    check("t3_beat2_cycles_on_bus", 32'(hold2), 32'd4);
    check("t3_done_cyc", 32'(done_cyc), 32'(e + 13));

    // Degenerate window: done 2 cycles after the edge, nothing sent.
    clear_log();
    start_xfer(2'd0, 2'd3, build(0), e);
    repeat (4) tick();
    check("t4_done_cyc",  32'(done_cyc),  32'(e + 1));
    check("t4_no_valid",  32'(first_vld), 32'hFFFF_FFFF);

    // Retrigger during SEND is ignored.
    clear_log();
    dc = done_cnt;
    start_xfer(2'd3, 2'd3, build(0), e);
    repeat (3) tick();
    unload_res = 1'b1;
    tick();
    unload_res = 1'b0;
    wait_done(30);
    repeat (10) tick();
    check("t5_beats", 32'(got_q.size()), 32'd9);
    check("t5_one_done", 32'(done_cnt - dc), 32'd1);

    // Reset at beat 4 with unload_res held high.
    clear_log();
    row_w      = 2'd3;
    col_x      = 2'd3;
    mac_res    = build(0);
    unload_res = 1'b1;
    repeat (5) tick();
    check("t6_beat4_on_bus", 32'(data_out), 32'd4);
    rst = 1'b1;
    tick();
    check("t6_rst_valid", 32'(valid_out), 32'd0);
    check("t6_rst_data",  32'(data_out),  32'd0);
    check("t6_rst_last",  32'(last_out),  32'd0);
    check("t6_rst_busy",  32'(busy),      32'd0);
    check("t6_rst_done",  32'(done),      32'd0);
    rst = 1'b0;
    n  = got_q.size();
    dc = done_cnt;
    repeat (10) tick();
    check("t6_no_restart_beats", 32'(got_q.size()), 32'(n));
    check("t6_no_done",          32'(done_cnt),     32'(dc));
    unload_res = 1'b0;
    tick();
    clear_log();
    start_xfer(2'd3, 2'd3, build(0), e);
    wait_done(30);
    check("t6_restart_beats", 32'(got_q.size()), 32'd9);

    // Clamp behaviour on element 0.
    clear_log();
    start_xfer(2'd3, 2'd3, build(2), e);
    wait_done(30);
    check("t7_beats", 32'(got_q.size()), 32'd9);
    if (got_q.size() == 9) begin
`ifdef RESULT_UNLOADER_CLAMP_EN
      check("t7_beat1", 32'(got_q[0]), 32'd255);
`else
      check("t7_beat1", 32'(got_q[0]), 32'd700);
`endif
      for (int i = 1; i < 9; i++) check("t7_beat", 32'(got_q[i]), 32'(i + 1));
    end

    // Randomized soak: the per-cycle model comparison does the checking.
    repeat (3000) begin
      rst = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 9) == 0) unload_res = ~unload_res;
      ready_out = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) begin
        row_w = 2'($urandom);
        col_x = 2'($urandom);
      end
      if ($urandom_range(0, 7) == 0) mac_res = 90'({$urandom, $urandom, $urandom});
      tick();
    end
    rst        = 1'b0;
    ready_out  = 1'b1;
    unload_res = 1'b0;
    repeat (40) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
